memory_stage: RTL

Memory-access stage directly downstream of the execute stage in the non-pipelined LEGv8 datapath. It latches the execute results on a `start` pulse and performs LDUR/STUR through a request/acknowledge data-memory port. It also resolves the branch decision (PCSrc) and signals completion to the control sequencer with a one-cycle `done` pulse. A watchdog and an alignment check report bus faults instead of hanging the core.

---
 rtl/memory_stage_pkg.sv | 17 +
 rtl/memory_stage_timeout_counter.sv | 27 ++
 rtl/memory_stage.sv | 128 ++++++++++++
 3 files changed

// File: rtl/memory_stage_pkg.sv
// Shared datapath width and memory-stage state encodings for the LEGv8 memory stage.
package memory_stage_pkg;

  localparam int unsigned WORD = 64;

  typedef enum logic [1:0] {
    MEM_IDLE   = 2'd0,
    MEM_ACCESS = 2'd1,
    MEM_DONE   = 2'd2
  } mem_state_e;

  // Doubleword accesses must sit on an 8-byte boundary.
  function automatic logic is_aligned(input logic [WORD-1:0] addr);
    return (addr[2:0] == 3'b000);
  endfunction

endpackage

// File: rtl/memory_stage_timeout_counter.sv
// Watchdog counter for the data-memory handshake; expired flags the last permitted wait cycle.
module timeout_counter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned   CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_count <= '0;
    end else if (enable && !expired) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign expired = (r_count == LAST);

endmodule

// File: rtl/memory_stage.sv
// Memory-access stage: latches execute results on start, runs LDUR/STUR over a req/ack port,
// resolves PCSrc and pulses done; misalignment, illegal control and timeouts raise fault.
import memory_stage_pkg::*;

module memory_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [WORD-1:0] alu_result,
  input  logic [WORD-1:0] read_data2,
  input  logic [WORD-1:0] branch_alu_result,
  input  logic            zero,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic            branch,
  input  logic            uncond_branch,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [WORD-1:0] dmem_addr,
  output logic [WORD-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [WORD-1:0] dmem_rdata,
  output logic [WORD-1:0] read_data,
  output logic            pc_src,
  output logic [WORD-1:0] branch_target,
  output logic            busy,
  output logic            done,
  output logic            fault
);

  mem_state_e r_state, w_next;

  logic [WORD-1:0] r_addr, r_wdata, r_rdata, r_target;
  logic            r_we, r_pc_src, r_fault;
  logic            w_accept, w_mem_op, w_bad_op, w_expired, w_in_access;

  assign w_accept    = (r_state == MEM_IDLE) && start;
  assign w_in_access = (r_state == MEM_ACCESS);
  assign w_mem_op    = mem_read | mem_write;
  assign w_bad_op    = (mem_read & mem_write) | (w_mem_op & ~is_aligned(alu_result));

  timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_accept),
    .enable  (w_in_access && !dmem_ack),
    .expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= MEM_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    busy       = (r_state != MEM_IDLE);
    done       = 1'b0;
    case (r_state)
      MEM_IDLE: begin
        if (start) begin
          w_next = (w_mem_op && !w_bad_op) ? MEM_ACCESS : MEM_DONE;
        end
      end
      MEM_ACCESS: begin
        dmem_req   = 1'b1;
        dmem_we    = r_we;
        dmem_addr  = r_addr;
        dmem_wdata = r_wdata;
        // An ack on the final permitted cycle wins over the watchdog.
        if (dmem_ack || w_expired) begin
          w_next = MEM_DONE;
        end
      end
      MEM_DONE: begin
        done   = 1'b1;
        w_next = MEM_IDLE;
      end
      default: begin
        w_next = MEM_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_target <= '0;
      r_we     <= 1'b0;
      r_pc_src <= 1'b0;
      r_fault  <= 1'b0;
    end else if (w_accept) begin
      r_addr   <= alu_result;
      r_wdata  <= read_data2;
      r_we     <= mem_write;
      r_target <= branch_alu_result;
      r_pc_src <= uncond_branch | (branch & zero);
      r_fault  <= w_bad_op;
    end else if (w_in_access) begin
      if (dmem_ack) begin
        if (!r_we) begin
          r_rdata <= dmem_rdata;
        end
      end else if (w_expired) begin
        r_fault <= 1'b1;
      end
    end
  end

  assign read_data     = r_rdata;
  assign pc_src        = r_pc_src;
  assign branch_target = r_target;
  assign fault         = r_fault;

endmodule
